// File: rtl/tabla_inst_pkg.sv
// Shared instruction-format constants and the PE fetch sequencer state type.
// INST_LEN is derived from the field widths so the fetcher and field decoder agree.
package tabla_inst_pkg;

    localparam int FN_LEN           = 5;
    localparam int NAME_LEN         = 3;
    localparam int WEIGHT_ADDR_LEN  = 10;
    localparam int INTERIM_ADDR_LEN = 10;
    localparam int PE_BUS_IDX_LEN   = 3;
    localparam int GB_BUS_IDX_LEN   = 3;

    // An operand index field must hold the widest of the addressable spaces.
    localparam int ADDR_IDX_MAX = (WEIGHT_ADDR_LEN > INTERIM_ADDR_LEN) ? WEIGHT_ADDR_LEN : INTERIM_ADDR_LEN;
    localparam int BUS_IDX_MAX  = (PE_BUS_IDX_LEN > GB_BUS_IDX_LEN) ? PE_BUS_IDX_LEN : GB_BUS_IDX_LEN;
    localparam int INDEX_LEN    = (ADDR_IDX_MAX > BUS_IDX_MAX) ? ADDR_IDX_MAX : BUS_IDX_MAX;

    // One destination and two sources, each a (name, index) pair.
    localparam int NUM_OPERANDS = 3;
    localparam int INST_LEN     = FN_LEN + NUM_OPERANDS * (NAME_LEN + INDEX_LEN);

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pe_inst_mem.sv
// Simple dual-port synchronous instruction RAM, read-first, with a resettable
// registered read port that doubles as the fetcher's instword output register.
module pe_inst_mem #(
    parameter int WIDTH    = tabla_inst_pkg::INST_LEN,
    parameter int ADDR_LEN = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_LEN-1:0] wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    input  logic [ADDR_LEN-1:0] rd_addr,
    output logic [WIDTH-1:0]    rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update of mem means a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pe_inst_fetch.sv
// Per-PE instruction fetch sequencer: streams the loaded microprogram on start.
// Define PE_INST_FETCH_LOOP_EN to repeat the program iter_count times per start.
module pe_inst_fetch #(
    parameter int INST_LEN = tabla_inst_pkg::INST_LEN,
    parameter int ADDR_LEN = 8,
    parameter int ITER_LEN = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_wr_en,
    input  logic [ADDR_LEN-1:0] inst_wr_addr,
    input  logic [INST_LEN-1:0] inst_wr_data,
    input  logic [ADDR_LEN:0]   inst_count,
    input  logic [ITER_LEN-1:0] iter_count,
    input  logic                start,
    input  logic                stall,
    output logic [INST_LEN-1:0] instword,
    output logic                instword_v,
    output logic                busy,
    output logic                done,
    output logic [ADDR_LEN-1:0] pc
);

    import tabla_inst_pkg::*;

    fetch_state_t        state_reg, state_next;
    logic [ADDR_LEN-1:0] pc_reg, pc_next;
    logic [ADDR_LEN:0]   len_reg, len_next;
    logic                instword_v_reg, instword_v_next;
    logic                done_reg, done_next;
    logic                rd_en;
    logic                last_inst;
    logic                last_pass;

    assign last_inst = ({1'b0, pc_reg} == (len_reg - (ADDR_LEN+1)'(1)));

`ifdef PE_INST_FETCH_LOOP_EN
    logic [ITER_LEN-1:0] iter_reg, iter_next;
    logic [ITER_LEN-1:0] it_reg, it_next;

    assign last_pass = (it_reg == (iter_reg - ITER_LEN'(1)));
`else
    logic unused_iter;

    assign unused_iter = ^iter_count;
    assign last_pass   = 1'b1;
`endif

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        len_next        = len_reg;
        instword_v_next = instword_v_reg;
        done_next       = 1'b0;
        rd_en           = 1'b0;
`ifdef PE_INST_FETCH_LOOP_EN
        iter_next       = iter_reg;
        it_next         = it_reg;
`endif
        case (state_reg)
            FETCH_IDLE: begin
                if (start) begin
                    len_next = inst_count;
                    pc_next  = '0;
`ifdef PE_INST_FETCH_LOOP_EN
                    it_next   = '0;
                    iter_next = (iter_count == '0) ? ITER_LEN'(1) : iter_count;
`endif
                    state_next = (inst_count == '0) ? FETCH_DONE : FETCH_RUN;
                end
            end
            FETCH_RUN: begin
                // A stalled cycle leaves the word, pc and pass counter untouched.
                if (!stall) begin
                    rd_en           = 1'b1;
                    instword_v_next = 1'b1;
                    pc_next         = pc_reg + ADDR_LEN'(1);
                    if (last_inst) begin
                        if (last_pass) begin
                            state_next = FETCH_DONE;
                        end else begin
                            pc_next = '0;
`ifdef PE_INST_FETCH_LOOP_EN
                            it_next = it_reg + ITER_LEN'(1);
`endif
                        end
                    end
                end
            end
            FETCH_DONE: begin
                if (!stall) begin
                    instword_v_next = 1'b0;
                    done_next       = 1'b1;
                    state_next      = FETCH_IDLE;
                end
            end
            default: begin
                state_next = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FETCH_IDLE;
            pc_reg         <= '0;
            len_reg        <= '0;
            instword_v_reg <= 1'b0;
            done_reg       <= 1'b0;
`ifdef PE_INST_FETCH_LOOP_EN
            iter_reg       <= '0;
            it_reg         <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            len_reg        <= len_next;
            instword_v_reg <= instword_v_next;
            done_reg       <= done_next;
`ifdef PE_INST_FETCH_LOOP_EN
            iter_reg       <= iter_next;
            it_reg         <= it_next;
`endif
        end
    end

    pe_inst_mem #(
        .WIDTH    (INST_LEN),
        .ADDR_LEN (ADDR_LEN)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (inst_wr_en),
        .wr_addr (inst_wr_addr),
        .wr_data (inst_wr_data),
        .rd_en   (rd_en),
        .rd_addr (pc_reg),
        .rd_data (instword)
    );

    assign instword_v = instword_v_reg;
    assign busy       = (state_reg != FETCH_IDLE);
    assign done       = done_reg;
    assign pc         = pc_reg;

endmodule

// File: tb/tb_pe_inst_fetch.sv
// Scoreboard bench for pe_inst_fetch: expected words come from a memory model
// and the program-repeat rule; a negedge monitor consumes them as they are issued.
module tb_pe_inst_fetch;

    localparam int IL  = 44;
    localparam int AL  = 8;
    localparam int ITL = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           inst_wr_en;
    logic [AL-1:0]  inst_wr_addr;
    logic [IL-1:0]  inst_wr_data;
    logic [AL:0]    inst_count;
    logic [ITL-1:0] iter_count;
    logic           start;
    logic           stall;
    logic [IL-1:0]  instword;
    logic           instword_v;
    logic           busy;
    logic           done;
    logic [AL-1:0]  pc;

    always #5 clk = ~clk;

    pe_inst_fetch #(.INST_LEN(IL), .ADDR_LEN(AL), .ITER_LEN(ITL)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_wr_en   (inst_wr_en),
        .inst_wr_addr (inst_wr_addr),
        .inst_wr_data (inst_wr_data),
        .inst_count   (inst_count),
        .iter_count   (iter_count),
        .start        (start),
        .stall        (stall),
        .instword     (instword),
        .instword_v   (instword_v),
        .busy         (busy),
        .done         (done),
        .pc           (pc)
    );

    logic [IL-1:0] mem_model [256];
    logic [IL-1:0] exp_q [$];
    logic [IL-1:0] mon_word;
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int pop_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // A word is consumed on an edge where it is valid and stall is low.
    always @(negedge clk) begin
        if (!reset) begin
            if (instword_v && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'(exp_q.size()), 64'(1));
                end else begin
                    mon_word = exp_q.pop_front();
                    pop_cnt++;
                    chk("word", 64'(instword), 64'(mon_word));
                    $display("issue word %0h (pc=%0d)", instword, pc);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_queue_empty", 64'(exp_q.size()), 64'(0));
                chk("done_v_low", 64'(instword_v), 64'(0));
                $display("done pulse #%0d", done_cnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [IL-1:0] data);
        inst_wr_en   = 1'b1;
        inst_wr_addr = AL'(addr);
        inst_wr_data = data;
        tick();
        inst_wr_en   = 1'b0;
        mem_model[addr] = data;
    endtask

    function automatic int passes(input int iter);
`ifdef PE_INST_FETCH_LOOP_EN
        return (iter == 0) ? 1 : iter;
`else
        return 1;
`endif
    endfunction

    // Expected stream: the first cnt memory words, repeated once per pass.
    task automatic push_run(input int cnt, input int iter);
        for (int p = 0; p < passes(iter); p++) begin
            for (int i = 0; i < cnt; i++) begin
                exp_q.push_back(mem_model[i]);
            end
        end
    endtask

    task automatic do_start(input int cnt, input int iter);
        inst_count = (AL+1)'(cnt);
        iter_count = ITL'(iter);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        chk("done_within_budget", 64'(ok), 64'(1));
    endtask

    // Unstalled run: 2-cycle start latency, gap-free stream, done right after.
    task automatic run_directed(input int cnt, input int iter);
        int total = cnt * passes(iter);
        push_run(cnt, iter);
        do_start(cnt, iter);
        chk("latency_v_low", 64'(instword_v), 64'(0));
        chk("busy_after_start", 64'(busy), 64'(1));
        for (int k = 0; k < total; k++) begin
            tick();
            chk("stream_v", 64'(instword_v), 64'(1));
        end
        tick();
        chk("done_after_stream", 64'(done), 64'(1));
        chk("busy_low_at_done", 64'(busy), 64'(0));
        tick();
    endtask

    initial begin
        int dc;
        int pc0;
        logic [IL-1:0] old_a2;
        reset        = 1'b1;
        inst_wr_en   = 1'b0;
        inst_wr_addr = '0;
        inst_wr_data = '0;
        inst_count   = '0;
        iter_count   = '0;
        start        = 1'b0;
        stall        = 1'b0;
        repeat (3) tick();
        chk("reset_instword", 64'(instword), 64'(0));
        chk("reset_v", 64'(instword_v), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_pc", 64'(pc), 64'(0));
        reset = 1'b0;
        tick();

        for (int a = 0; a < 256; a++) wr(a, IL'({$urandom(), $urandom()}));
        for (int a = 0; a < 4; a++) wr(a, 44'hA00_0000_0000 | IL'(a));

        // Basic 4-word single pass.
        run_directed(4, 1);

        // Stall for 3 cycles while A1 is presented.
        pc0 = pop_cnt;
        push_run(4, 1);
        do_start(4, 1);
        tick();
        tick();
        chk("stall_pre_a1", 64'(instword), 64'(mem_model[1]));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold_word", 64'(instword), 64'(mem_model[1]));
            chk("stall_hold_v", 64'(instword_v), 64'(1));
        end
        stall = 1'b0;
        tick();
        chk("after_stall_a2", 64'(instword), 64'(mem_model[2]));
        tick();
        chk("after_stall_a3", 64'(instword), 64'(mem_model[3]));
        tick();
        chk("stall_run_done", 64'(done), 64'(1));
        chk("stall_distinct_words", 64'(pop_cnt - pc0), 64'(4));
        tick();

        // Multi-pass (or single pass without looping) with no wrap bubble.
        run_directed(3, 2);

        // Zero-length program.
        do_start(0, 1);
        chk("cnt0_v", 64'(instword_v), 64'(0));
        chk("cnt0_busy", 64'(busy), 64'(1));
        chk("cnt0_done_early", 64'(done), 64'(0));
        tick();
        chk("cnt0_done", 64'(done), 64'(1));
        chk("cnt0_v_after", 64'(instword_v), 64'(0));
        tick();
        chk("cnt0_idle", 64'(busy), 64'(0));

        // start while busy is ignored.
        pc0 = pop_cnt;
        dc  = done_cnt;
        push_run(4, 1);
        do_start(4, 1);
        tick();
        inst_count = 9'd2;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        wait_done(50, 1'b0);
        repeat (3) tick();
        chk("busy_start_words", 64'(pop_cnt - pc0), 64'(4));
        chk("busy_start_dones", 64'(done_cnt - dc), 64'(1));

        // Reset at the second valid word.
        push_run(4, 1);
        do_start(4, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_v", 64'(instword_v), 64'(0));
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_pc", 64'(pc), 64'(0));
        chk("rst_mid_done", 64'(done), 64'(0));
        reset = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        repeat (4) tick();
        chk("rst_mid_no_done", 64'(done_cnt), 64'(dc));
        run_directed(4, 1);

        // Same-cycle write and read of address 2 returns the old word.
        old_a2 = mem_model[2];
        push_run(4, 1);
        do_start(4, 1);
        tick();
        tick();
        inst_wr_en   = 1'b1;
        inst_wr_addr = 8'd2;
        inst_wr_data = 44'hB00_0000_00B2;
        tick();
        inst_wr_en   = 1'b0;
        mem_model[2] = 44'hB00_0000_00B2;
        chk("collision_old_word", 64'(instword), 64'(old_a2));
        wait_done(50, 1'b0);
        tick();
        run_directed(4, 1);

        // Randomized programs, lengths, pass counts and stalls.
        for (int r = 0; r < 25; r++) begin
            int cnt;
            int iter;
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
                wr(int'($urandom_range(0, 15)), IL'({$urandom(), $urandom()}));
            end
            cnt  = (r == 7) ? 256 : (r == 13) ? 255 : int'($urandom_range(0, 12));
            iter = int'($urandom_range(0, 3));
            push_run(cnt, iter);
            do_start(cnt, iter);
            wait_done(4000, 1'b1);
            repeat (2) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
